// File: rtl/fx_dsp_pkg.sv
// Shared definitions for the fixed-point band-power datapath: sign-magnitude
// field layout, band count, default window length and FSM state encoding.
package fx_dsp_pkg;
   localparam int SM_W         = 16;
   localparam int SM_SIGN_BIT  = 15;
   localparam int SM_MAG_W     = 15;
   localparam int NBANDS       = 4;
   localparam int WIN_LOG2_DEF = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MAC    = 2'd1,
      ST_FINISH = 2'd2
   } state_e;
endpackage

// File: rtl/fx_sm_square.sv
// Combinational square of a Q0.15 sign-magnitude sample, returning the top
// 16 bits of the 30-bit product (truncated). Negative zero squares to zero.
module fx_sm_square
   import fx_dsp_pkg::*;
(
   input  logic [SM_W-1:0] sm_in,
   output logic [SM_W-1:0] sq
);
   logic [SM_MAG_W-1:0]   mag;
   logic [2*SM_MAG_W-1:0] prod;
   logic                  unused_sign;

   // Squaring discards the sign, so only the magnitude feeds the multiplier.
   assign unused_sign = sm_in[SM_SIGN_BIT];

   always_comb begin
      mag  = sm_in[SM_MAG_W-1:0];
      prod = {{SM_MAG_W{1'b0}}, mag} * {{SM_MAG_W{1'b0}}, mag};
      sq   = prod[2*SM_MAG_W-1 -: SM_W];
   end
endmodule

// File: rtl/band_power_accum.sv
// Per-band energy accumulator: squares four band samples per tick with one
// shared squarer and reports mean power and dominant band every window.
module band_power_accum
   import fx_dsp_pkg::*;
#(
   parameter int WIN_LOG2 = WIN_LOG2_DEF,
   parameter int ACC_W    = 16 + WIN_LOG2
) (
   input  logic        clk_slow,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] band_in_0,
   input  logic [15:0] band_in_1,
   input  logic [15:0] band_in_2,
   input  logic [15:0] band_in_3,
   output logic        busy,
   output logic [15:0] pwr_0,
   output logic [15:0] pwr_1,
   output logic [15:0] pwr_2,
   output logic [15:0] pwr_3,
   output logic [1:0]  dom_band,
   output logic        out_valid,
   output logic        overrun
);
   state_e              state_q, state_d;
   logic                pend_q, pend_d;
   logic [1:0]          idx_q, idx_d;
   logic [WIN_LOG2-1:0] cnt_q, cnt_d;
   logic [SM_W-1:0]     lat_q [NBANDS];
   logic [SM_W-1:0]     lat_d [NBANDS];
   logic [ACC_W-1:0]    acc_q [NBANDS];
   logic [ACC_W-1:0]    acc_d [NBANDS];
   logic [15:0]         pwr_q [NBANDS];
   logic [15:0]         pwr_d [NBANDS];
   logic [15:0]         pwr_new [NBANDS];
   logic [1:0]          dom_q, dom_d, dom_new;
   logic                out_valid_q, out_valid_d;
   logic                overrun_q, overrun_d;
   logic                busy_w;
   logic [SM_W-1:0]     sq_w;

   // pend_q covers the latch cycle between acceptance and the first MAC step.
   assign busy_w = pend_q | (state_q != ST_IDLE);

   fx_sm_square u_sq (
      .sm_in (lat_q[idx_q]),
      .sq    (sq_w)
   );

   // Window mean is a plain shift; strict '>' keeps ties on the lowest index.
   always_comb begin
      dom_new = '0;
      for (int k = 0; k < NBANDS; k++) pwr_new[k] = acc_q[k][ACC_W-1:WIN_LOG2];
      for (int k = 1; k < NBANDS; k++) begin
         if (pwr_new[k] > pwr_new[dom_new]) dom_new = 2'(k);
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      lat_d       = lat_q;
      acc_d       = acc_q;
      pwr_d       = pwr_q;
      dom_d       = dom_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;

      if (in_valid) begin
         if (busy_w) begin
            overrun_d = 1'b1;
         end else begin
            lat_d[0] = band_in_0;
            lat_d[1] = band_in_1;
            lat_d[2] = band_in_2;
            lat_d[3] = band_in_3;
            pend_d   = 1'b1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               pend_d  = 1'b0;
               idx_d   = 2'd0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d[idx_q] = acc_q[idx_q] + {{(ACC_W-SM_W){1'b0}}, sq_w};
            idx_d        = idx_q + 2'd1;
            if (idx_q == 2'(NBANDS-1)) begin
               if (cnt_q == '1) begin
                  state_d = ST_FINISH;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FINISH: begin
            for (int k = 0; k < NBANDS; k++) begin
               pwr_d[k] = pwr_new[k];
               acc_d[k] = '0;
            end
            dom_d       = dom_new;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_slow or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         pend_q      <= 1'b0;
         idx_q       <= '0;
         cnt_q       <= '0;
         dom_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int k = 0; k < NBANDS; k++) begin
            lat_q[k] <= '0;
            acc_q[k] <= '0;
            pwr_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         dom_q       <= dom_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         lat_q       <= lat_d;
         acc_q       <= acc_d;
         pwr_q       <= pwr_d;
      end
   end

   assign busy      = busy_w;
   assign pwr_0     = pwr_q[0];
   assign pwr_1     = pwr_q[1];
   assign pwr_2     = pwr_q[2];
   assign pwr_3     = pwr_q[3];
   assign dom_band  = dom_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
endmodule

// File: tb/tb_band_power_accum.sv
// Directed/random bench for band_power_accum with an arithmetic reference
// model of the windowed mean power and dominant band.
module tb_band_power_accum;
   logic        clk_slow = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] band_in_0, band_in_1, band_in_2, band_in_3;
   logic        busy;
   logic [15:0] pwr_0, pwr_1, pwr_2, pwr_3;
   logic [1:0]  dom_band;
   logic        out_valid;
   logic        overrun;

   int          tests = 0;
   int          fails = 0;
   int          ov_count = 0;
   int          ov_base = 0;
   longint      m_acc [4];
   int          m_cnt = 0;
   logic [15:0] exp_pwr [4];
   logic [1:0]  exp_dom;

   band_power_accum dut (
      .clk_slow  (clk_slow),
      .rst       (rst),
      .in_valid  (in_valid),
      .band_in_0 (band_in_0),
      .band_in_1 (band_in_1),
      .band_in_2 (band_in_2),
      .band_in_3 (band_in_3),
      .busy      (busy),
      .pwr_0     (pwr_0),
      .pwr_1     (pwr_1),
      .pwr_2     (pwr_2),
      .pwr_3     (pwr_3),
      .dom_band  (dom_band),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

   always #5 clk_slow = ~clk_slow;

   always @(negedge clk_slow) if (out_valid === 1'b1) ov_count++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_clear();
      for (int k = 0; k < 4; k++) m_acc[k] = 0;
      m_cnt = 0;
   endfunction

   // Returns 1 when this tick completes a 64-tick window.
   function automatic bit model_tick(input logic [15:0] b0, input logic [15:0] b1,
                                     input logic [15:0] b2, input logic [15:0] b3);
      logic [15:0] b [4];
      longint      mag;
      b = '{b0, b1, b2, b3};
      for (int k = 0; k < 4; k++) begin
         mag = longint'(b[k] & 16'h7FFF);
         m_acc[k] += (mag * mag) / 16384;
      end
      m_cnt++;
      if (m_cnt == 64) begin
         for (int k = 0; k < 4; k++) exp_pwr[k] = 16'(m_acc[k] / 64);
         exp_dom = 2'd0;
         for (int k = 1; k < 4; k++) if (exp_pwr[k] > exp_pwr[exp_dom]) exp_dom = 2'(k);
         model_clear();
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic tick(input logic [15:0] b0, input logic [15:0] b1,
                       input logic [15:0] b2, input logic [15:0] b3, input bit inj);
      bit fin;
      band_in_0 = b0; band_in_1 = b1; band_in_2 = b2; band_in_3 = b3;
      in_valid  = 1'b1;
      fin = model_tick(b0, b1, b2, b3);
      @(posedge clk_slow); #1;
      in_valid = 1'b0;
      chk("busy_rise", busy, 1);
      chk("ov_width", out_valid, 0);
      if (inj) begin
         @(posedge clk_slow); #1;
         band_in_0 = 16'h7FFF; band_in_1 = 16'h7FFF; band_in_2 = 16'h7FFF; band_in_3 = 16'h7FFF;
         in_valid = 1'b1;
         @(posedge clk_slow); #1;
         in_valid = 1'b0;
         chk("overrun_set", overrun, 1);
         repeat (3) @(posedge clk_slow);
         #1;
      end else begin
         repeat (5) @(posedge clk_slow);
         #1;
      end
      if (!fin) begin
         chk("busy_fall", busy, 0);
      end else begin
         chk("ov_early", out_valid, 0);
         chk("finish_busy", busy, 1);
         @(posedge clk_slow); #1;
         chk("ov_pulse", out_valid, 1);
         chk("idle_at_ov", busy, 0);
         chk("pwr_0", pwr_0, exp_pwr[0]);
         chk("pwr_1", pwr_1, exp_pwr[1]);
         chk("pwr_2", pwr_2, exp_pwr[2]);
         chk("pwr_3", pwr_3, exp_pwr[3]);
         chk("dom_band", dom_band, exp_dom);
         chk("ov_count", ov_count, ov_base);
         ov_base = ov_count + 1;
      end
   endtask

   function automatic logic [15:0] rnd_sample();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return 16'h8000;
      if (sel == 1) return 16'h7FFF;
      return 16'($urandom());
   endfunction

   // mode 0: all 0x4000, 1: band2 full scale, 2: alternating sign on band1,
   // 3: negative zero / LSB-only, 4: random.
   task automatic run_window(input int mode, input int nticks, input int inj_at);
      logic [15:0] b0, b1, b2, b3;
      for (int t = 0; t < nticks; t++) begin
         case (mode)
            0: begin b0 = 16'h4000; b1 = 16'h4000; b2 = 16'h4000; b3 = 16'h4000; end
            1: begin b0 = 16'h0000; b1 = 16'h0000; b2 = 16'h7FFF; b3 = 16'h0000; end
            2: begin b0 = 16'h0000; b1 = (t % 2 == 0) ? 16'h4000 : 16'hC000; b2 = 16'h0000; b3 = 16'h2000; end
            3: begin b0 = 16'h8000; b1 = 16'h0000; b2 = 16'h0000; b3 = 16'h0001; end
            default: begin b0 = rnd_sample(); b1 = rnd_sample(); b2 = rnd_sample(); b3 = rnd_sample(); end
         endcase
         tick(b0, b1, b2, b3, t == inj_at);
      end
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      band_in_0 = '0; band_in_1 = '0; band_in_2 = '0; band_in_3 = '0;
      model_clear();
      repeat (2) @(posedge clk_slow);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_pwr", {pwr_0, pwr_1}, 0);
      chk("rst_pwr_hi", {pwr_2, pwr_3}, 0);
      chk("rst_dom", dom_band, 0);
      rst = 1'b1;
      @(posedge clk_slow); #1;

      run_window(0, 64, -1);
      chk("no_overrun", overrun, 0);
      run_window(1, 64, -1);
      run_window(2, 64, -1);
      run_window(4, 64, 5);
      chk("overrun_sticky", overrun, 1);

      run_window(4, 30, -1);
      chk("pwr_held", {pwr_0, pwr_1, pwr_2, pwr_3}, {exp_pwr[0], exp_pwr[1], exp_pwr[2], exp_pwr[3]});
      chk("overrun_held", overrun, 1);
      rst = 1'b0;
      #2;
      chk("mid_rst_pwr", {pwr_0, pwr_1, pwr_2, pwr_3}, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dom", dom_band, 0);
      model_clear();
      @(posedge clk_slow); #1;
      rst = 1'b1;
      @(posedge clk_slow); #1;

      run_window(0, 64, -1);
      run_window(3, 64, -1);
      for (int w = 0; w < 3; w++) run_window(4, 64, -1);

      repeat (10) @(posedge clk_slow);
      #1;
      chk("final_ov_count", ov_count, ov_base);
      chk("final_overrun", overrun, 0);
      chk("final_dom_held", dom_band, exp_dom);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
